// File: rtl/pwm_csr_bank.sv
// rtl/pwm_csr_bank.sv - SPI byte-stream register bank driving NUM_CH double-buffered PWM channels
module pwm_csr_bank #(
  parameter int NUM_CH = 7,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [7:0]        data_in,
  input  logic              data_rdy,
  input  logic              frame,
  output logic [7:0]        data_out,
  output logic              data_latch,
  output logic [NUM_CH-1:0] chip_out
);

  typedef enum logic [1:0] {IDLE, DATA0, DATA1} state_t;

  localparam logic [1:0] REG_DUTY = 2'd0;
  localparam logic [1:0] REG_PER  = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  low_q, low_d;
  logic [7:0]  rd_hi_q, rd_hi_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_latch_q, data_latch_d;

  logic [CNT_W-1:0] duty_sh_q  [NUM_CH];
  logic [CNT_W-1:0] duty_sh_d  [NUM_CH];
  logic [CNT_W-1:0] per_sh_q   [NUM_CH];
  logic [CNT_W-1:0] per_sh_d   [NUM_CH];
  logic [CNT_W-1:0] duty_act_q [NUM_CH];
  logic [CNT_W-1:0] duty_act_d [NUM_CH];
  logic [CNT_W-1:0] per_act_q  [NUM_CH];
  logic [CNT_W-1:0] per_act_d  [NUM_CH];
  logic [CNT_W-1:0] cnt_q      [NUM_CH];
  logic [CNT_W-1:0] cnt_d      [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d, inv_q, inv_d, out_q, out_d, clr_v;

  logic [15:0] wdata;
  logic [15:0] rd_val;
  logic        commit;

  assign wdata  = {data_in, low_q};
  assign commit = frame && data_rdy && (state_q == DATA1) && cmd_q[7];

  // Read snapshot is taken from the command byte itself, before it is registered.
  always_comb begin
    rd_val = 16'h0000;
    for (int i = 0; i < NUM_CH; i++) begin
      if (data_in[6:2] == 5'(i)) begin
        case (data_in[1:0])
          REG_DUTY: rd_val = 16'(duty_sh_q[i]);
          REG_PER:  rd_val = 16'(per_sh_q[i]);
          REG_CTRL: rd_val = {14'b0, inv_q[i], en_q[i]};
          default:  rd_val = 16'(cnt_q[i]);
        endcase
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    low_d        = low_q;
    rd_hi_d      = rd_hi_q;
    data_out_d   = data_out_q;
    data_latch_d = 1'b0;
    if (!frame) begin
      state_d = IDLE;
    end else if (data_rdy) begin
      case (state_q)
        IDLE: begin
          cmd_d   = data_in;
          state_d = DATA0;
          if (!data_in[7]) begin
            rd_hi_d      = rd_val[15:8];
            data_out_d   = rd_val[7:0];
            data_latch_d = 1'b1;
          end
        end
        DATA0: begin
          low_d   = data_in;
          state_d = DATA1;
          if (!cmd_q[7]) begin
            data_out_d   = rd_hi_q;
            data_latch_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Active registers load the pre-edge shadow, so a commit coinciding with a wrap waits one period.
  always_comb begin
    clr_v = '0;
    en_d  = en_q;
    inv_d = inv_q;
    for (int i = 0; i < NUM_CH; i++) begin
      duty_sh_d[i]  = duty_sh_q[i];
      per_sh_d[i]   = per_sh_q[i];
      duty_act_d[i] = duty_act_q[i];
      per_act_d[i]  = per_act_q[i];
      cnt_d[i]      = cnt_q[i];
      if (commit && cmd_q[6:2] == 5'(i)) begin
        case (cmd_q[1:0])
          REG_DUTY: duty_sh_d[i] = wdata[CNT_W-1:0];
          REG_PER:  per_sh_d[i]  = wdata[CNT_W-1:0];
          REG_CTRL: begin
            en_d[i]  = wdata[0];
            inv_d[i] = wdata[1];
            clr_v[i] = wdata[2];
          end
          default: ;
        endcase
      end
      if (!en_q[i] || clr_v[i] || cnt_q[i] == per_act_q[i]) begin
        cnt_d[i]      = '0;
        duty_act_d[i] = duty_sh_q[i];
        per_act_d[i]  = per_sh_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      out_d[i] = en_q[i] ? ((cnt_q[i] < duty_act_q[i]) ^ inv_q[i]) : inv_q[i];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      low_q        <= '0;
      rd_hi_q      <= '0;
      data_out_q   <= '0;
      data_latch_q <= 1'b0;
      en_q         <= '0;
      inv_q        <= '0;
      out_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh_q[i]  <= '0;
        per_sh_q[i]   <= '0;
        duty_act_q[i] <= '0;
        per_act_q[i]  <= '0;
        cnt_q[i]      <= '0;
      end
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      low_q        <= low_d;
      rd_hi_q      <= rd_hi_d;
      data_out_q   <= data_out_d;
      data_latch_q <= data_latch_d;
      en_q         <= en_d;
      inv_q        <= inv_d;
      out_q        <= out_d;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        per_sh_q[i]   <= per_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
        per_act_q[i]  <= per_act_d[i];
        cnt_q[i]      <= cnt_d[i];
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_latch = data_latch_q;
  assign chip_out   = out_q;

endmodule

// File: tb/tb_pwm_csr_bank.sv
// tb/tb_pwm_csr_bank.sv - randomized bench for pwm_csr_bank against a behavioural register/PWM model
module tb_pwm_csr_bank;
  localparam int NCH = 7;
  localparam int W   = 16;

  logic           sys_clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     data_in = 8'h00;
  logic           data_rdy = 1'b0;
  logic           frame = 1'b0;
  logic [7:0]     data_out;
  logic           data_latch;
  logic [NCH-1:0] chip_out;

  int errors = 0;
  int checks = 0;
  int printed = 0;
  bit use_gaps = 1'b0;

  pwm_csr_bank #(.NUM_CH(NCH), .CNT_W(W)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_rdy   (data_rdy),
    .frame      (frame),
    .data_out   (data_out),
    .data_latch (data_latch),
    .chip_out   (chip_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (printed < 40) begin
        printed++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Behavioural model: registers as plain integers, one step per rising edge.
  int m_dsh[NCH], m_psh[NCH], m_dact[NCH], m_pact[NCH], m_cnt[NCH];
  bit [NCH-1:0] m_en, m_inv, m_chip;
  int m_dout, m_latch, m_idx, m_cmd, m_low, m_snap;
  bit m_valid = 1'b0;

  function automatic int reg_value(input int ch, input int r);
    if (ch >= NCH) return 0;
    case (r)
      0: return m_dsh[ch];
      1: return m_psh[ch];
      2: return int'(m_en[ch]) + 2 * int'(m_inv[ch]);
      default: return m_cnt[ch];
    endcase
  endfunction

  always @(posedge sys_clk) begin
    int wch, wr, wv;
    bit [NCH-1:0] nchip, clr;
    wch = -1; wr = 0; wv = 0; clr = '0; nchip = '0;
    m_valid = 1'b1;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_dsh[i] = 0; m_psh[i] = 0; m_dact[i] = 0; m_pact[i] = 0; m_cnt[i] = 0;
      end
      m_en = '0; m_inv = '0; m_chip = '0;
      m_dout = 0; m_latch = 0; m_idx = 0; m_cmd = 0; m_low = 0; m_snap = 0;
    end else begin
      for (int i = 0; i < NCH; i++)
        nchip[i] = m_en[i] ? ((m_cnt[i] < m_dact[i]) ^ m_inv[i]) : m_inv[i];
      m_latch = 0;
      if (!frame) m_idx = 0;
      else if (data_rdy) begin
        if (m_idx == 0) begin
          m_cmd = int'(data_in);
          if (m_cmd < 128) begin
            m_snap  = reg_value((m_cmd / 4) % 32, m_cmd % 4);
            m_dout  = m_snap % 256;
            m_latch = 1;
          end
          m_idx = 1;
        end else if (m_idx == 1) begin
          m_low = int'(data_in);
          if (m_cmd < 128) begin
            m_dout  = m_snap / 256;
            m_latch = 1;
          end
          m_idx = 2;
        end else begin
          m_idx = 0;
          if (m_cmd >= 128 && (m_cmd / 4) % 32 < NCH && m_cmd % 4 != 3) begin
            wch = (m_cmd / 4) % 32;
            wr  = m_cmd % 4;
            wv  = (int'(data_in) * 256 + m_low) % (1 << W);
          end
        end
      end
      if (wch >= 0 && wr == 2) clr[wch] = ((wv >> 2) & 1) == 1;
      for (int i = 0; i < NCH; i++) begin
        if (!m_en[i] || clr[i] || m_cnt[i] == m_pact[i]) begin
          m_cnt[i] = 0; m_dact[i] = m_dsh[i]; m_pact[i] = m_psh[i];
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (wch >= 0) begin
        case (wr)
          0: m_dsh[wch] = wv;
          1: m_psh[wch] = wv;
          default: begin
            m_en[wch]  = (wv & 1) == 1;
            m_inv[wch] = ((wv >> 1) & 1) == 1;
          end
        endcase
      end
      m_chip = nchip;
    end
  end

  always @(negedge sys_clk) begin
    if (m_valid) begin
      check("model_chip_out", 32'(chip_out), 32'(m_chip));
      check("model_data_out", 32'(data_out), 32'(m_dout));
      check("model_data_latch", 32'(data_latch), 32'(m_latch));
    end
  end

  task automatic gap();
    if (use_gaps) repeat ($urandom_range(0, 2)) begin @(posedge sys_clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in = b; data_rdy = 1'b1;
    @(posedge sys_clk); #1;
    data_rdy = 1'b0;
  endtask

  task automatic write_reg(input int ch, input int r, input int val);
    frame = 1'b1;
    send_byte(8'(128 + ch * 4 + r)); gap();
    send_byte(8'(val)); gap();
    send_byte(8'(val >> 8));
    frame = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  task automatic read_reg(input int ch, input int r, output int lo, output int hi, output int lat);
    frame = 1'b1;
    send_byte(8'(ch * 4 + r));
    @(negedge sys_clk); lo = int'(data_out); lat = int'(data_latch);
    gap(); send_byte(8'hA5);
    @(negedge sys_clk); hi = int'(data_out); lat = lat + int'(data_latch);
    gap(); send_byte(8'h5A);
    frame = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  task automatic count_high(input int ch, input int n, output int hi, output int rises);
    bit prev;
    hi = 0; rises = 0; prev = chip_out[ch];
    repeat (n) begin
      @(negedge sys_clk);
      if (chip_out[ch]) hi++;
      if (chip_out[ch] && !prev) rises++;
      prev = chip_out[ch];
    end
  endtask

  initial begin
    int bad, lat_seen, lo, hi, lat, rises, h0, h1, found, ch, r, kind, val;
    bit prev;
    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b0;

    bad = 0; lat_seen = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (chip_out !== '0 || data_out !== 8'h00) bad++;
      if (data_latch !== 1'b0) lat_seen++;
    end
    check("reset_idle_outputs", bad, 0);
    check("reset_idle_latch", lat_seen, 0);

    write_reg(0, 1, 9); write_reg(0, 0, 3); write_reg(0, 2, 1);
    repeat (25) @(posedge sys_clk); #1;
    count_high(0, 30, hi, rises);
    check("basic_high_30", hi, 9);
    check("basic_rises_30", rises, 3);
    read_reg(0, 0, lo, hi, lat);
    check("basic_read_lo", lo, 8'h03);
    check("basic_read_hi", hi, 8'h00);
    check("basic_read_latch", lat, 2);

    write_reg(2, 1, 99); write_reg(2, 0, 50); write_reg(2, 2, 1);
    found = 0; prev = chip_out[2];
    for (int k = 0; k < 300 && found == 0; k++) begin
      @(negedge sys_clk);
      if (chip_out[2] && !prev) found = 1;
      prev = chip_out[2];
    end
    check("dbuf_rise_found", found, 1);
    h0 = 1; h1 = 0;
    fork
      begin
        for (int k = 1; k < 200; k++) begin
          @(negedge sys_clk);
          if (chip_out[2]) begin
            if (k < 100) h0++; else h1++;
          end
        end
      end
      begin
        repeat (60) @(posedge sys_clk);
        #1 write_reg(2, 0, 10);
      end
    join
    check("dbuf_first_period_high", h0, 50);
    check("dbuf_second_period_high", h1, 10);
    write_reg(2, 2, 3);
    count_high(2, 100, hi, rises);
    check("dbuf_inverted_high", hi, 90);

    write_reg(1, 1, 0); write_reg(1, 0, 1); write_reg(1, 2, 1);
    repeat (3) @(posedge sys_clk); #1;
    count_high(1, 20, hi, rises);
    check("period0_const_high", hi, 20);
    write_reg(3, 0, 200); write_reg(3, 1, 99); write_reg(3, 2, 1);
    repeat (3) @(posedge sys_clk); #1;
    count_high(3, 30, hi, rises);
    check("duty_gt_period_high", hi, 30);

    write_reg(31, 0, 16'hABCD);
    read_reg(31, 0, lo, hi, lat);
    check("ch31_read_lo", lo, 0);
    check("ch31_read_hi", hi, 0);

    frame = 1'b1;
    send_byte(8'h90); send_byte(8'h34);
    frame = 1'b0;
    @(posedge sys_clk); #1;
    read_reg(4, 0, lo, hi, lat);
    check("abort_duty_lo", lo, 0);
    check("abort_duty_hi", hi, 0);
    write_reg(4, 0, 16'h0055);
    read_reg(4, 0, lo, hi, lat);
    check("after_abort_lo", lo, 8'h55);
    check("after_abort_hi", hi, 8'h00);

    write_reg(5, 0, 16'hBEEF);
    read_reg(5, 0, lo, hi, lat);
    check("ch5_read_lo", lo, 8'hEF);
    check("ch5_read_hi", hi, 8'hBE);

    frame = 1'b1;
    send_byte(8'h88); send_byte(8'h77);
    data_in = 8'h66; data_rdy = 1'b1; rst = 1'b1;
    @(posedge sys_clk); #1;
    data_rdy = 1'b0; frame = 1'b0;
    @(negedge sys_clk);
    check("midrst_chip_out", 32'(chip_out), 0);
    check("midrst_data_out", 32'(data_out), 0);
    check("midrst_data_latch", 32'(data_latch), 0);
    #1 rst = 1'b0;
    @(posedge sys_clk); #1;
    read_reg(2, 0, lo, hi, lat);
    check("midrst_ch2_duty", hi * 256 + lo, 0);
    read_reg(0, 2, lo, hi, lat);
    check("midrst_ch0_ctrl", hi * 256 + lo, 0);

    use_gaps = 1'b1;
    for (int t = 0; t < 220; t++) begin
      ch = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, NCH));
      r = int'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 9));
      if (kind < 5) begin
        val = (r == 2) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 24));
        if ($urandom_range(0, 7) == 0) val = int'($urandom);
        write_reg(ch, r, val);
      end else if (kind < 9) begin
        read_reg(ch, r, lo, hi, lat);
      end else begin
        frame = 1'b1;
        send_byte(8'($urandom));
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
        frame = 1'b0;
        @(posedge sys_clk); #1;
      end
      repeat ($urandom_range(0, 15)) @(posedge sys_clk);
      #1;
    end
    repeat (50) @(posedge sys_clk);
    @(negedge sys_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_csr_bank.md
# pwm_csr_bank

Parametrised successor to the single-channel PWM control logic: a byte-stream register block that decodes SPI command/data bytes and drives a bank of `NUM_CH` independent PWM channels. Each channel has double-buffered duty/period registers, enable and polarity control, and a readable live counter. It sits between the SPI byte interface and the chip output pins, and runs entirely in the `sys_clk` domain.

## Interface
- `NUM_CH`, default 7: number of PWM channels, range 1..32.
- `CNT_W`, default 16: width of the counter, duty and period, range 1..16.

- `sys_clk`  in  1  system clock; every register changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `data_in`  in  8  byte received from the SPI block; valid when `data_rdy`=1.
- `data_rdy`  in  1  one-cycle strobe, already synchronised to `sys_clk`.
- `frame`  in  1  SPI chip-select active (high); low forces the FSM to IDLE.
- `data_out`  out  8  byte the SPI block shifts out on the next transfer.
- `data_latch`  out  1  one-cycle pulse: `data_out` has just been updated.
- `chip_out`  out  NUM_CH  PWM outputs, bit i = channel i.

## Operation
- **Transaction:** command byte, then exactly two data bytes (low byte first, then high byte).
- **Command byte fields:**
  - bit7: 1 = write, 0 = read.
  - bits[6:2]: channel index.
  - bits[1:0]: register select.
    - 0 = DUTY.
    - 1 = PERIOD.
    - 2 = CTRL: bit0 enable, bit1 invert, bit2 counter-clear (self-clearing, reads 0).
    - 3 = CNT: read-only live counter.
- **FSM states and transitions:**
  - IDLE → DATA0 on a command strobe.
  - DATA0 → DATA1 on the next strobe.
  - DATA1 → IDLE on the next strobe.
  - Any state → IDLE when `frame`=0; a partial transaction is discarded and nothing is committed.
- **Write path:**
  - DATA0 stores the low byte in a holding register.
  - DATA1 commits {high, low} to the target register. The value is truncated to `CNT_W` bits.
  - A DUTY/PERIOD write goes to the shadow register. CTRL takes effect immediately.
  - Writes to CNT, or to a channel index ≥ `NUM_CH`, are ignored.
- **Read path:**
  - On the command strobe, the target register (zero-extended to 16 bits) is snapshotted into a 16-bit holding register.
  - DUTY/PERIOD reads return the shadow value.
  - A channel index ≥ `NUM_CH` reads 0x0000.
  - `data_out` is the low byte after the command strobe, and the high byte after the DATA0 strobe.
  - Data bytes received during a read are dummies and are ignored.
- **PWM channel, when enabled:**
  - The counter runs 0..period_act. When the counter equals period_act it wraps to 0, and the shadow duty/period are loaded into the active registers on that same edge.
  - `chip_out[i]` = (cnt < duty_act) XOR invert.
- **Boundary behaviour:**
  - period = 0: the counter stays at 0. duty ≥ 1 gives a constant active level; duty = 0 gives a constant inactive level.
  - duty > period: the output is 100% active.
- **Disabled channel:**
  - The counter is held at 0.
  - The shadow is copied into the active registers every cycle.
  - Output = invert.
- **Counter-clear:** forces cnt to 0 and loads the shadow into the active registers on the commit edge.
- **Simultaneous shadow commit and wrap:** the active registers load the old shadow. The new value takes effect at the following wrap.

## Timing
- **Reset values:**
  - All duty, period, CTRL and counter registers are 0.
  - FSM in IDLE.
  - `data_out`=0x00, `data_latch`=0, `chip_out`=0.
- **Reset mid-transaction:** aborts the transaction with no commit.
- **Write latency:**
  - The shadow/CTRL register updates on the edge that samples the DATA1 strobe.
  - Enable/invert changes are visible on `chip_out` one cycle later.
  - A new duty/period reaches the active registers at the next wrap.
- **Read latency:**
  - `data_out`/`data_latch` update one cycle after the command strobe (low byte).
  - They update again one cycle after the DATA0 strobe (high byte).
  - `data_latch` is high for exactly one cycle each time.
- **`data_out` between updates:** holds its value; it is not cleared in IDLE.
- **`chip_out`:** registered, one cycle behind the counter compare.
- **Strobe spacing:** back-to-back `data_rdy` on consecutive cycles must be accepted, one byte per strobe.

## Test plan
- **Reset values:** reset, then idle 20 cycles → `chip_out`=0, `data_out`=0x00, `data_latch` never pulses.
- **Basic PWM:** ch0 write PERIOD=9, DUTY=3, CTRL=0x01 → `chip_out[0]` has period 10 cycles, high 3 cycles. Read DUTY → bytes 0x03, 0x00 with two `data_latch` pulses.
- **Double-buffered update:** while ch2 runs PERIOD=99/DUTY=50, write DUTY=10 mid-period → current period still high 50 cycles, next period high 10. Write CTRL=0x03 → output inverted from the next cycle.
- **Edge cases:**
  - PERIOD=0 with DUTY=1 → `chip_out` constantly 1.
  - DUTY=200 with PERIOD=99 → constantly 1.
  - Channel 31 with `NUM_CH`=7: write ignored, read returns 0x00, 0x00.
- **Aborted frame:** drop `frame` after the DATA0 byte of a write DUTY=0x1234 → register unchanged. The next full transaction decodes correctly.
- **Reset mid-operation:** assert `rst` during DATA1 and during active PWM → all outputs and registers return to reset values on the next edge.
